seq_subtractor: RTL

//  Parametrised multi-cycle subtractor: computes DIFF = A - B - BIN over WIDTH bits,

---
 rtl/seq_sub_pkg.sv | 20 ++
 rtl/sub_digit.sv | 23 ++
 rtl/seq_subtractor.sv | 115 +++++++++++
 3 files changed

// File: rtl/seq_sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
// Holds the FSM state encoding, the counter width rule and the overflow rule.
package seq_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-digit configuration still needs a 1-bit counter.
    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

    function automatic logic ovf_of(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational ripple of DIGIT full-subtractor cells: {bout, d} = a - b - bin.
module sub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] brw;

    assign brw[0] = bin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        assign d[i]       = a[i] ^ b[i] ^ brw[i];
        assign brw[i+1]   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
    end

    assign bout = brw[DIGIT];

endmodule

// File: rtl/seq_subtractor.sv
// Digit-serial subtractor: DIFF = A - B - BIN, DIGIT bits per clock, LSB digit first.
// Results are registered and held until the next job completes.
module seq_subtractor
    import seq_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int            NDIG = WIDTH / DIGIT;
    localparam int            CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic [WIDTH-1:0] a_nx, b_nx, res_nx;
    logic             brw;
    logic             a_msb, b_msb;
    logic [DIGIT-1:0] dig_d;
    logic             dig_bout;
    logic             accept;
    logic             last;

    sub_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (a_sh[DIGIT-1:0]),
        .b    (b_sh[DIGIT-1:0]),
        .bin  (brw),
        .d    (dig_d),
        .bout (dig_bout)
    );

    // Result digits enter from the top so the LSB digit lands at bit 0 after NDIG shifts.
    if (DIGIT == WIDTH) begin : g_single
        assign a_nx   = '0;
        assign b_nx   = '0;
        assign res_nx = dig_d;
    end else begin : g_multi
        assign a_nx   = {{DIGIT{1'b0}}, a_sh[WIDTH-1:DIGIT]};
        assign b_nx   = {{DIGIT{1'b0}}, b_sh[WIDTH-1:DIGIT]};
        assign res_nx = {dig_d, res_sh[WIDTH-1:DIGIT]};
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = (cnt == LAST);
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN:     if (last) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            brw    <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            a_sh   <= a;
            b_sh   <= b;
            brw    <= bin;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
        end else if (state == RUN) begin
            cnt    <= cnt + 1'b1;
            a_sh   <= a_nx;
            b_sh   <= b_nx;
            res_sh <= res_nx;
            brw    <= dig_bout;
            if (last) begin
                diff <= res_nx;
                bout <= dig_bout;
                ovf  <= ovf_of(a_msb, b_msb, res_nx[WIDTH-1]);
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
